// File: rtl/sar_search.sv
// Successive-approximation search engine: drives a trial word into an external
// magnitude comparator and converges on the comparator's A operand.
module sar_search #(
    parameter int WIDTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic [WIDTH-1:0]             trial,
    input  logic                         a_gt_b,
    input  logic                         a_eq_b,
    input  logic                         a_lt_b,
    output logic                         busy,
    output logic                         done,
    output logic [WIDTH-1:0]             result,
    output logic                         err,
    output logic [$clog2(WIDTH+1)-1:0]   steps
);

    localparam int SW = $clog2(WIDTH + 1);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] TRY  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [WIDTH-1:0] ONE_WORD = WIDTH'(1);
    localparam logic [WIDTH-1:0] MSB_WORD = ONE_WORD << (WIDTH - 1);
    localparam logic [IW-1:0]    TOP_IDX  = IW'(WIDTH - 1);

    // Exactly one of the three comparator flags may be asserted.
    function automatic logic is_one_hot3(input logic [2:0] f);
        logic ok;
        case (f)
            3'b001, 3'b010, 3'b100: ok = 1'b1;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    logic [1:0]       state_r,  state_s;
    logic [WIDTH-1:0] trial_r,  trial_s;
    logic [IW-1:0]    idx_r,    idx_s;
    logic             busy_r,   busy_s;
    logic             done_r,   done_s;
    logic [WIDTH-1:0] result_r, result_s;
    logic             err_r,    err_s;
    logic [SW-1:0]    steps_r,  steps_s;

    logic [2:0]       flags_s;
    logic [WIDTH-1:0] bit_mask_s;
    logic [WIDTH-1:0] adj_s;

    assign flags_s    = {a_gt_b, a_eq_b, a_lt_b};
    assign bit_mask_s = ONE_WORD << idx_r;
    // Target below trial means the bit under test overshoots and must be dropped.
    assign adj_s      = a_lt_b ? (trial_r & ~bit_mask_s) : trial_r;

    // Next-state and next-output computation for the search FSM.
    always_comb begin
        state_s  = state_r;
        trial_s  = trial_r;
        idx_s    = idx_r;
        busy_s   = busy_r;
        done_s   = 1'b0;
        result_s = result_r;
        err_s    = err_r;
        steps_s  = steps_r;
        case (state_r)
            IDLE: begin
                trial_s = {WIDTH{1'b0}};
                busy_s  = 1'b0;
                if (start) begin
                    state_s  = TRY;
                    trial_s  = MSB_WORD;
                    idx_s    = TOP_IDX;
                    busy_s   = 1'b1;
                    result_s = {WIDTH{1'b0}};
                    err_s    = 1'b0;
                    steps_s  = {SW{1'b0}};
                end else begin
                    state_s = IDLE;
                end
            end
            TRY: begin
                steps_s = steps_r + SW'(1);
                if (!is_one_hot3(flags_s)) begin
                    err_s    = 1'b1;
                    result_s = {WIDTH{1'b0}};
                    state_s  = DONE;
                end else if (a_eq_b) begin
                    result_s = trial_r;
                    state_s  = DONE;
                end else if (idx_r != {IW{1'b0}}) begin
                    trial_s = adj_s | (bit_mask_s >> 1);
                    idx_s   = idx_r - IW'(1);
                end else begin
                    result_s = adj_s;
                    state_s  = DONE;
                end
                if (state_s == DONE) begin
                    trial_s = {WIDTH{1'b0}};
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                end else begin
                    busy_s  = 1'b1;
                end
            end
            DONE: begin
                state_s = IDLE;
                trial_s = {WIDTH{1'b0}};
                busy_s  = 1'b0;
            end
            default: begin
                state_s = IDLE;
                trial_s = {WIDTH{1'b0}};
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears everything and aborts a search.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            trial_r  <= {WIDTH{1'b0}};
            idx_r    <= {IW{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= {WIDTH{1'b0}};
            err_r    <= 1'b0;
            steps_r  <= {SW{1'b0}};
        end else begin
            state_r  <= state_s;
            trial_r  <= trial_s;
            idx_r    <= idx_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            result_r <= result_s;
            err_r    <= err_s;
            steps_r  <= steps_s;
        end
    end

    assign trial  = trial_r;
    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;
    assign err    = err_r;
    assign steps  = steps_r;

endmodule
